// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared pipeline definitions: datapath widths, ALU op encodings, the
// ID/EX register bundle and the write-back bypass rule used when operands
// are captured into EX.
package id_ex_pipe_reg_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 3;
  localparam int CNT_W   = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_addr_t;

  // ALU operation encodings carried on ALUOp through the pipeline
  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_OR    = 3'd3,
    ALU_AND   = 3'd4,
    ALU_SLT   = 3'd5,
    ALU_LUI   = 3'd6,
    ALU_XOR   = 3'd7
  } alu_op_e;

  // Everything the EX stage receives from ID
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    data_t              rs_data;
    data_t              rt_data;
    data_t              imm;
    reg_addr_t          rs_addr;
    reg_addr_t          rt_addr;
    reg_addr_t          rd_addr;
  } ex_bundle_t;

  // A register-file write in this same cycle supersedes the stale read value;
  // register 0 is hard-wired and never bypassed.
  function automatic data_t wb_bypass(input logic      wb_we,
                                      input reg_addr_t wb_rd,
                                      input data_t     wb_data,
                                      input reg_addr_t src_addr,
                                      input data_t     src_data);
    if (wb_we && (wb_rd != '0) && (wb_rd == src_addr)) return wb_data;
    return src_data;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX has not yet fetched from memory.
module load_use_detect
  import id_ex_pipe_reg_pkg::*;
(
  input  logic      ex_valid,
  input  logic      ex_mem_read,
  input  reg_addr_t ex_rt_addr,
  input  logic      id_valid,
  input  reg_addr_t id_rs_addr,
  input  reg_addr_t id_rt_addr,
  output logic      hazard
);

  // Register 0 is never a real dependency, so a load targeting it is ignored
  always_comb begin
    hazard = ex_valid && ex_mem_read && id_valid && (ex_rt_addr != '0) &&
             ((ex_rt_addr == id_rs_addr) || (ex_rt_addr == id_rt_addr));
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush / load-use bubbles,
// write-back bypass on operand capture and a saturating bubble counter.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ID_Valid_i,
  input  logic               ID_RegWrite_i,
  input  logic               ID_MemtoReg_i,
  input  logic               ID_MemRead_i,
  input  logic               ID_MemWrite_i,
  input  logic               ID_ALUSrc_i,
  input  logic [ALUOP_W-1:0] ID_ALUOp_i,
  input  logic [DATA_W-1:0]  ID_RsData_i,
  input  logic [DATA_W-1:0]  ID_RtData_i,
  input  logic [DATA_W-1:0]  ID_Imm_i,
  input  logic [REG_W-1:0]   ID_RsAddr_i,
  input  logic [REG_W-1:0]   ID_RtAddr_i,
  input  logic [REG_W-1:0]   ID_RdAddr_i,
  input  logic               WB_RegWrite_i,
  input  logic [REG_W-1:0]   WB_RdAddr_i,
  input  logic [DATA_W-1:0]  WB_Data_i,
  input  logic               Stall_i,
  input  logic               Flush_i,
  output logic               EX_Valid_o,
  output logic               EX_RegWrite_o,
  output logic               EX_MemtoReg_o,
  output logic               EX_MemRead_o,
  output logic               EX_MemWrite_o,
  output logic               EX_ALUSrc_o,
  output logic [ALUOP_W-1:0] EX_ALUOp_o,
  output logic [DATA_W-1:0]  EX_RsData_o,
  output logic [DATA_W-1:0]  EX_RtData_o,
  output logic [DATA_W-1:0]  EX_Imm_o,
  output logic [REG_W-1:0]   EX_RsAddr_o,
  output logic [REG_W-1:0]   EX_RtAddr_o,
  output logic [REG_W-1:0]   EX_RdAddr_o,
  output logic               Hazard_o,
  output logic [CNT_W-1:0]   BubbleCnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_bundle_t       ex_reg;
  ex_bundle_t       ex_next;
  ex_bundle_t       load_bundle;
  logic [CNT_W-1:0] bubble_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_next;
  logic             hazard;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_reg.valid),
    .ex_mem_read (ex_reg.mem_read),
    .ex_rt_addr  (ex_reg.rt_addr),
    .id_valid    (ID_Valid_i),
    .id_rs_addr  (ID_RsAddr_i),
    .id_rt_addr  (ID_RtAddr_i),
    .hazard      (hazard)
  );

  // What a normal load would capture; an empty ID slot loads as a bubble
  always_comb begin
    load_bundle = '0;
    if (ID_Valid_i) begin
      load_bundle.valid      = 1'b1;
      load_bundle.reg_write  = ID_RegWrite_i;
      load_bundle.mem_to_reg = ID_MemtoReg_i;
      load_bundle.mem_read   = ID_MemRead_i;
      load_bundle.mem_write  = ID_MemWrite_i;
      load_bundle.alu_src    = ID_ALUSrc_i;
      load_bundle.alu_op     = ID_ALUOp_i;
      load_bundle.rs_data    = wb_bypass(WB_RegWrite_i, WB_RdAddr_i, WB_Data_i,
                                         ID_RsAddr_i, ID_RsData_i);
      load_bundle.rt_data    = wb_bypass(WB_RegWrite_i, WB_RdAddr_i, WB_Data_i,
                                         ID_RtAddr_i, ID_RtData_i);
      load_bundle.imm        = ID_Imm_i;
      load_bundle.rs_addr    = ID_RsAddr_i;
      load_bundle.rt_addr    = ID_RtAddr_i;
      load_bundle.rd_addr    = ID_RdAddr_i;
    end
  end

  // Flush outranks the hazard, so a squashed slot never counts as a load-use bubble
  always_comb begin
    ex_next         = load_bundle;
    bubble_cnt_next = bubble_cnt_reg;
    if (Flush_i) begin
      ex_next = '0;
    end else if (hazard) begin
      ex_next = '0;
      if (bubble_cnt_reg != CNT_MAX) bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
    end
  end

  // Stall freezes the whole stage, counter included
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_reg         <= '0;
      bubble_cnt_reg <= '0;
    end else if (!Stall_i) begin
      ex_reg         <= ex_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  assign EX_Valid_o    = ex_reg.valid;
  assign EX_RegWrite_o = ex_reg.reg_write;
  assign EX_MemtoReg_o = ex_reg.mem_to_reg;
  assign EX_MemRead_o  = ex_reg.mem_read;
  assign EX_MemWrite_o = ex_reg.mem_write;
  assign EX_ALUSrc_o   = ex_reg.alu_src;
  assign EX_ALUOp_o    = ex_reg.alu_op;
  assign EX_RsData_o   = ex_reg.rs_data;
  assign EX_RtData_o   = ex_reg.rt_data;
  assign EX_Imm_o      = ex_reg.imm;
  assign EX_RsAddr_o   = ex_reg.rs_addr;
  assign EX_RtAddr_o   = ex_reg.rt_addr;
  assign EX_RdAddr_o   = ex_reg.rd_addr;
  assign Hazard_o      = hazard;
  assign BubbleCnt_o   = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, reset and saturation
// sequences, then randomized traffic against a reference model.
module tb_id_ex_pipe_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ID_Valid_i, ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i;
  logic [2:0]  ID_ALUOp_i;
  logic [31:0] ID_RsData_i, ID_RtData_i, ID_Imm_i;
  logic [4:0]  ID_RsAddr_i, ID_RtAddr_i, ID_RdAddr_i;
  logic        WB_RegWrite_i;
  logic [4:0]  WB_RdAddr_i;
  logic [31:0] WB_Data_i;
  logic        Stall_i, Flush_i;
  logic        EX_Valid_o, EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o;
  logic [2:0]  EX_ALUOp_o;
  logic [31:0] EX_RsData_o, EX_RtData_o, EX_Imm_o;
  logic [4:0]  EX_RsAddr_o, EX_RtAddr_o, EX_RdAddr_o;
  logic        Hazard_o;
  logic [15:0] BubbleCnt_o;

  id_ex_pipe_reg dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_Valid_i(ID_Valid_i), .ID_RegWrite_i(ID_RegWrite_i), .ID_MemtoReg_i(ID_MemtoReg_i),
    .ID_MemRead_i(ID_MemRead_i), .ID_MemWrite_i(ID_MemWrite_i), .ID_ALUSrc_i(ID_ALUSrc_i),
    .ID_ALUOp_i(ID_ALUOp_i), .ID_RsData_i(ID_RsData_i), .ID_RtData_i(ID_RtData_i),
    .ID_Imm_i(ID_Imm_i), .ID_RsAddr_i(ID_RsAddr_i), .ID_RtAddr_i(ID_RtAddr_i),
    .ID_RdAddr_i(ID_RdAddr_i), .WB_RegWrite_i(WB_RegWrite_i), .WB_RdAddr_i(WB_RdAddr_i),
    .WB_Data_i(WB_Data_i), .Stall_i(Stall_i), .Flush_i(Flush_i),
    .EX_Valid_o(EX_Valid_o), .EX_RegWrite_o(EX_RegWrite_o), .EX_MemtoReg_o(EX_MemtoReg_o),
    .EX_MemRead_o(EX_MemRead_o), .EX_MemWrite_o(EX_MemWrite_o), .EX_ALUSrc_o(EX_ALUSrc_o),
    .EX_ALUOp_o(EX_ALUOp_o), .EX_RsData_o(EX_RsData_o), .EX_RtData_o(EX_RtData_o),
    .EX_Imm_o(EX_Imm_o), .EX_RsAddr_o(EX_RsAddr_o), .EX_RtAddr_o(EX_RtAddr_o),
    .EX_RdAddr_o(EX_RdAddr_o), .Hazard_o(Hazard_o), .BubbleCnt_o(BubbleCnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        valid, rw, m2r, mr, mw, as;
    logic [2:0]  aluop;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
  } ex_t;

  typedef struct packed {
    ex_t         id;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, flush;
  } in_t;

  typedef struct {
    in_t         in;
    logic        haz, valid, mr;
    logic [31:0] rsd, rtd;
    logic [15:0] cnt;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  ex_t  m_ex;
  logic [15:0] m_cnt;
  vec_t tbl[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: what EX should hold after an edge, from the pipeline rules
  function automatic logic m_hazard(input in_t i);
    return m_ex.valid && m_ex.mr && i.id.valid && (m_ex.rt != 5'd0) &&
           ((m_ex.rt == i.id.rs) || (m_ex.rt == i.id.rt));
  endfunction

  task automatic m_step(input in_t i);
    ex_t nx;
    logic h;
    h = m_hazard(i);
    if (i.stall) return;
    if (i.flush) m_ex = '0;
    else if (h) begin
      m_ex = '0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (!i.id.valid) m_ex = '0;
    else begin
      nx = i.id;
      if (i.wb_rw && i.wb_rd != 5'd0 && i.wb_rd == nx.rs) nx.rsd = i.wb_data;
      if (i.wb_rw && i.wb_rd != 5'd0 && i.wb_rd == nx.rt) nx.rtd = i.wb_data;
      m_ex = nx;
    end
  endtask

  task automatic drive(input in_t i);
    ID_Valid_i = i.id.valid; ID_RegWrite_i = i.id.rw; ID_MemtoReg_i = i.id.m2r;
    ID_MemRead_i = i.id.mr; ID_MemWrite_i = i.id.mw; ID_ALUSrc_i = i.id.as;
    ID_ALUOp_i = i.id.aluop; ID_RsData_i = i.id.rsd; ID_RtData_i = i.id.rtd;
    ID_Imm_i = i.id.imm; ID_RsAddr_i = i.id.rs; ID_RtAddr_i = i.id.rt; ID_RdAddr_i = i.id.rd;
    WB_RegWrite_i = i.wb_rw; WB_RdAddr_i = i.wb_rd; WB_Data_i = i.wb_data;
    Stall_i = i.stall; Flush_i = i.flush;
  endtask

  function automatic ex_t dut_ex();
    ex_t d;
    d.valid = EX_Valid_o; d.rw = EX_RegWrite_o; d.m2r = EX_MemtoReg_o; d.mr = EX_MemRead_o;
    d.mw = EX_MemWrite_o; d.as = EX_ALUSrc_o; d.aluop = EX_ALUOp_o; d.rsd = EX_RsData_o;
    d.rtd = EX_RtData_o; d.imm = EX_Imm_o; d.rs = EX_RsAddr_o; d.rt = EX_RtAddr_o;
    d.rd = EX_RdAddr_o;
    return d;
  endfunction

  // Starts just after a falling edge, ends on the next falling edge
  task automatic run_cycle(input in_t i, input string tag, output logic haz_seen);
    drive(i);
    #1;
    haz_seen = Hazard_o;
    check({tag, "_hazard"}, 160'(Hazard_o), 160'(m_hazard(i)));
    @(posedge clk_i);
    m_step(i);
    #1;
    $display("%s: valid=%0b rs=%h rt=%h haz=%0b cnt=%0h", tag, EX_Valid_o, EX_RsData_o,
             EX_RtData_o, haz_seen, BubbleCnt_o);
    check({tag, "_ex"}, 160'(dut_ex()), 160'(m_ex));
    check({tag, "_cnt"}, 160'(BubbleCnt_o), 160'(m_cnt));
    @(negedge clk_i);
  endtask

  function automatic in_t mk(input logic v, input logic mr, input logic [4:0] rs,
                             input logic [31:0] rsd, input logic [4:0] rt,
                             input logic [31:0] rtd, input logic [4:0] rd);
    in_t i;
    i = '0;
    i.id.valid = v; i.id.rw = 1'b1; i.id.m2r = mr; i.id.mr = mr; i.id.as = mr;
    i.id.aluop = mr ? 3'd0 : 3'd2;
    i.id.rsd = rsd; i.id.rtd = rtd; i.id.imm = v ? 32'h10 + 32'(rd) : 32'd0;
    i.id.rs = rs; i.id.rt = rt; i.id.rd = rd;
    return i;
  endfunction

  function automatic in_t wb(input in_t i, input logic rw, input logic [4:0] rd, input logic [31:0] d);
    in_t o;
    o = i; o.wb_rw = rw; o.wb_rd = rd; o.wb_data = d;
    return o;
  endfunction

  function automatic in_t ctl(input in_t i, input logic stall, input logic flush);
    in_t o;
    o = i; o.stall = stall; o.flush = flush;
    return o;
  endfunction

  task automatic add_vec(input in_t i, input logic haz, input logic valid, input logic mr,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] cnt);
    vec_t v;
    v.in = i; v.haz = haz; v.valid = valid; v.mr = mr; v.rsd = rsd; v.rtd = rtd; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  function automatic in_t rand_in();
    in_t r;
    r = '0;
    r.id.valid = ($urandom_range(0, 9) != 0);
    r.id.rw = 1'($urandom); r.id.m2r = 1'($urandom); r.id.mw = 1'($urandom);
    r.id.as = 1'($urandom); r.id.aluop = 3'($urandom);
    r.id.mr = ($urandom_range(0, 2) == 0);
    r.id.rsd = $urandom; r.id.rtd = $urandom; r.id.imm = $urandom;
    r.id.rs = 5'($urandom_range(0, 7)); r.id.rt = 5'($urandom_range(0, 7));
    r.id.rd = 5'($urandom_range(0, 31));
    r.wb_rw = 1'($urandom); r.wb_rd = 5'($urandom_range(0, 7)); r.wb_data = $urandom;
    r.stall = ($urandom_range(0, 6) == 0);
    r.flush = ($urandom_range(0, 9) == 0);
    if (!r.id.valid) begin
      r.id.rw = 1'b0; r.id.m2r = 1'b0; r.id.mr = 1'b0; r.id.mw = 1'b0; r.id.as = 1'b0;
      r.id.aluop = 3'd0; r.id.rsd = 32'd0; r.id.rtd = 32'd0; r.id.imm = 32'd0;
      r.wb_rw = 1'b0;
    end
    return r;
  endfunction

  initial begin
    logic h;
    in_t  add_i;

    // Directed table: {inputs, hazard, EX valid, EX memread, EX rs, EX rt, count}
    add_vec(mk(1, 0, 3, 32'h11, 4, 32'h22, 5),                 0, 1, 0, 32'h11, 32'h22, 0);
    add_vec(mk(1, 1, 1, 32'h100, 8, 32'h55, 0),                0, 1, 1, 32'h100, 32'h55, 0);
    add_vec(mk(1, 0, 8, 32'h77, 9, 32'h99, 10),                1, 0, 0, 32'h0, 32'h0, 1);
    add_vec(mk(1, 0, 8, 32'h77, 9, 32'h99, 10),                0, 1, 0, 32'h77, 32'h99, 1);
    add_vec(wb(mk(1, 0, 7, 32'hDEAD, 2, 32'h1234, 3), 1, 7, 32'hBEEF), 0, 1, 0, 32'hBEEF, 32'h1234, 1);
    add_vec(wb(mk(1, 0, 0, 32'hDEAD, 0, 32'h4321, 3), 1, 0, 32'hBEEF), 0, 1, 0, 32'hDEAD, 32'h4321, 1);
    add_vec(wb(mk(1, 0, 5, 32'h1, 6, 32'h2, 3), 1, 6, 32'hCAFE),       0, 1, 0, 32'h1, 32'hCAFE, 1);
    add_vec(wb(mk(1, 0, 6, 32'h3, 6, 32'h4, 3), 0, 6, 32'hCAFE),       0, 1, 0, 32'h3, 32'h4, 1);
    add_vec(wb(mk(1, 0, 12, 32'h5, 12, 32'h6, 3), 1, 12, 32'hF00D),    0, 1, 0, 32'hF00D, 32'hF00D, 1);
    add_vec(mk(1, 1, 1, 32'h200, 8, 32'h300, 0),               0, 1, 1, 32'h200, 32'h300, 1);
    add_vec(ctl(mk(1, 0, 2, 32'h5, 8, 32'h6, 11), 1, 1),       1, 1, 1, 32'h200, 32'h300, 1);
    add_vec(ctl(mk(1, 0, 2, 32'h5, 8, 32'h6, 11), 1, 0),       1, 1, 1, 32'h200, 32'h300, 1);
    add_vec(ctl(mk(1, 0, 2, 32'h5, 8, 32'h6, 11), 0, 1),       1, 0, 0, 32'h0, 32'h0, 1);
    add_vec(mk(1, 0, 2, 32'h5, 8, 32'h6, 11),                  0, 1, 0, 32'h5, 32'h6, 1);
    add_vec(mk(1, 1, 1, 32'h400, 8, 32'h500, 0),               0, 1, 1, 32'h400, 32'h500, 1);
    add_vec(mk(0, 0, 8, 32'h0, 8, 32'h0, 0),                   0, 0, 0, 32'h0, 32'h0, 1);
    add_vec(mk(1, 1, 1, 32'h600, 0, 32'h700, 0),               0, 1, 1, 32'h600, 32'h700, 1);
    add_vec(mk(1, 0, 0, 32'h800, 0, 32'h900, 4),               0, 1, 0, 32'h800, 32'h900, 1);

    // Reset state
    rst_i = 1'b1;
    drive('0);
    repeat (2) @(negedge clk_i);
    check("reset_ex", 160'(dut_ex()), 160'(0));
    check("reset_cnt", 160'(BubbleCnt_o), 160'(0));
    check("reset_haz", 160'(Hazard_o), 160'(0));
    rst_i = 1'b0;
    m_ex = '0;
    m_cnt = 16'd0;

    foreach (tbl[k]) begin
      run_cycle(tbl[k].in, $sformatf("tbl%0d", k), h);
      check($sformatf("tbl%0d_haz", k), 160'(h), 160'(tbl[k].haz));
      check($sformatf("tbl%0d_valid", k), 160'(EX_Valid_o), 160'(tbl[k].valid));
      check($sformatf("tbl%0d_memread", k), 160'(EX_MemRead_o), 160'(tbl[k].mr));
      check($sformatf("tbl%0d_rsdata", k), 160'(EX_RsData_o), 160'(tbl[k].rsd));
      check($sformatf("tbl%0d_rtdata", k), 160'(EX_RtData_o), 160'(tbl[k].rtd));
      check($sformatf("tbl%0d_cnt", k), 160'(BubbleCnt_o), 160'(tbl[k].cnt));
    end

    // Asynchronous reset in the middle of a stalled load-use
    run_cycle(mk(1, 1, 1, 32'h11, 8, 32'h22, 0), "rst_pre", h);
    add_i = mk(1, 0, 8, 32'h33, 9, 32'h44, 12);
    drive(ctl(add_i, 1, 0));
    #1;
    check("rst_stall_haz", 160'(Hazard_o), 160'(1));
    rst_i = 1'b1;
    #1;
    check("rst_async_ex", 160'(dut_ex()), 160'(0));
    check("rst_async_cnt", 160'(BubbleCnt_o), 160'(0));
    check("rst_async_haz", 160'(Hazard_o), 160'(0));
    rst_i = 1'b0;
    m_ex = '0;
    m_cnt = 16'd0;
    #1;
    run_cycle(add_i, "rst_post", h);
    check("rst_post_valid", 160'(EX_Valid_o), 160'(1));
    check("rst_post_rs", 160'(EX_RsData_o), 160'(32'h33));

    // Randomized traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        m_ex = '0;
        m_cnt = 16'd0;
      end
      run_cycle(rand_in(), "rnd", h);
    end

    // Counter saturation from a preloaded 0xFFFE
    run_cycle(ctl(mk(1, 0, 0, 32'h1, 0, 32'h2, 1), 0, 1), "sat_flush", h);
    force dut.bubble_cnt_reg = 16'hFFFE;
    #1;
    release dut.bubble_cnt_reg;
    m_cnt = 16'hFFFE;
    run_cycle(mk(1, 1, 1, 32'h10, 8, 32'h20, 0), "sat_lw1", h);
    run_cycle(mk(1, 0, 8, 32'h30, 9, 32'h40, 10), "sat_bub1", h);
    check("sat_first", 160'(BubbleCnt_o), 160'(16'hFFFF));
    run_cycle(mk(1, 0, 8, 32'h30, 9, 32'h40, 10), "sat_add1", h);
    run_cycle(mk(1, 1, 1, 32'h10, 8, 32'h20, 0), "sat_lw2", h);
    run_cycle(mk(1, 0, 3, 32'h30, 8, 32'h40, 10), "sat_bub2", h);
    check("sat_hold_haz", 160'(h), 160'(1));
    check("sat_stays", 160'(BubbleCnt_o), 160'(16'hFFFF));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
